uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Sits between UART_RX and Pong_Top. It consumes the received byte stream (rx_dv/rx_byte) and turns ASCII keystrokes into game control: a one-cycle game-start pulse and four level-held paddle controls. It holds a run/pause/idle game mode and counts unrecognised bytes.
The paddle outputs replace or OR with the debounced switch inputs, and game_start_o replaces the raw rx_dv start.

Parameters:
HOLD_CLKS, 2_500_000, clocks a paddle output stays asserted after its last command (100 ms at 25 MHz); must be >= 1.
HOLD_W, 22, width of each hold counter; 2^HOLD_W must be > HOLD_CLKS.

Ports:
clk_i  input  1  system clock (25 MHz)
rst_i  input  1  asynchronous, active-high reset
rx_dv_i  input  1  one-cycle byte-valid strobe from UART_RX
rx_byte_i  input  8  received byte, valid when rx_dv_i=1
game_start_o  output  1  one-cycle pulse to Pong_Top Game_Start_i
p1_up_o  output  1  player 1 paddle up (level)
p1_down_o  output  1  player 1 paddle down (level)
p2_up_o  output  1  player 2 paddle up (level)
p2_down_o  output  1  player 2 paddle down (level)
mode_o  output  2  0=IDLE, 1=RUN, 2=PAUSE
bad_cmd_cnt_o  output  8  saturating count of unrecognised bytes

Behaviour:
- Reset (async, rst_i=1): mode=IDLE; all hold counters=0; all outputs 0; bad_cmd_cnt_o=0.
- All outputs are registered. The effect of a byte accepted at edge N is visible after edge N+1.
- Command map (exact byte compare, case-sensitive):
  - 0x53 'S' start
  - 0x70 'p' pause toggle
  - 0x71 'q' quit
  - 0x20 space: release all
  - 0x77 'w' P1 up; 0x73 's' P1 down
  - 0x6F 'o' P2 up; 0x6C 'l' P2 down
- Any other byte: bad_cmd_cnt_o += 1, saturating at 255. Mode and holds are unchanged. Counted in every mode.
- FSM:
  - IDLE: 'S' -> RUN and game_start_o=1 for exactly one cycle. All other recognised bytes are ignored (not counted).
  - RUN:
    - 'p' -> PAUSE and clears all holds.
    - 'q' -> IDLE and clears all holds.
    - Paddle commands: load that direction's counter with HOLD_CLKS and clear the opposite direction of the same player to 0.
    - Space clears all four counters.
    - 'S' is ignored.
  - PAUSE:
    - 'p' -> RUN (no start pulse).
    - 'S' -> RUN with a game_start_o pulse.
    - 'q' -> IDLE.
    - Paddle commands and space are ignored.
- Hold counters: each is HOLD_W bits and decrements by 1 per cycle while nonzero; it never wraps below 0. Its paddle output = (counter != 0) && mode==RUN.
- Timing: a single command yields exactly HOLD_CLKS cycles of assertion. A repeat command while the counter is nonzero reloads it to HOLD_CLKS, giving continuous assertion with no gap.
- Up and down of the same player are never high together. The latest command wins.
- Players are independent. A P2 command does not affect P1 counters.
- game_start_o never asserts on consecutive cycles; rx_dv_i is a single-cycle strobe at least CLKS_PER_BIT apart.
- rx_dv_i=0: rx_byte_i is ignored entirely.
- rst_i asserted mid-hold or mid-pulse: outputs drop to 0 immediately (asynchronous). The first edge after deassertion evaluates rx_dv_i normally.

Test Plan:
1. Reset, then byte 'S' -> game_start_o high exactly 1 cycle at N+1; mode_o=1.
2. In RUN, 'w' with HOLD_CLKS=10 -> p1_up_o high for exactly 10 cycles starting N+1, then 0. A second 'w' at cycle 5 extends it to 15 total with no gap.
3. In RUN, 'w' then 's' 3 cycles later -> p1_up_o falls and p1_down_o rises on the same edge, never both high. A concurrent 'o' keeps p2_up_o unaffected.
4. In RUN, hold active, then 'p' -> all paddle outputs 0, mode_o=2. Then 'w' is ignored. Then 'S' -> mode_o=1 plus a 1-cycle game_start_o. Then 'q' -> mode_o=0.
5. In IDLE, send 'w', 'p', 0x41, 0xFF -> no paddle or start activity, mode_o=0, bad_cmd_cnt_o=2. Send 300 bad bytes -> bad_cmd_cnt_o saturates at 255.
6. Assert rst_i for a fraction of a cycle mid-hold -> p1_up_o and mode_o go 0 without a clock edge. After release, 'S' restarts normally.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Connects UART_RX bytes to the decoder, and carries the decoder's game control
// outputs to Pong_Top.
interface uart_cmd_decoder_if;
  logic       rx_dv_i;
  logic [7:0] rx_byte_i;
  logic       game_start_o;
  logic       p1_up_o;
  logic       p1_down_o;
  logic       p2_up_o;
  logic       p2_down_o;
  logic [1:0] mode_o;
  logic [7:0] bad_cmd_cnt_o;

  modport master (
    output rx_dv_i, rx_byte_i,
    input  game_start_o, p1_up_o, p1_down_o, p2_up_o, p2_down_o, mode_o, bad_cmd_cnt_o
  );

  modport slave (
    input  rx_dv_i, rx_byte_i,
    output game_start_o, p1_up_o, p1_down_o, p2_up_o, p2_down_o, mode_o, bad_cmd_cnt_o
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Turns ASCII keystrokes from UART_RX into a game-start pulse, held paddle levels
// and an IDLE/RUN/PAUSE mode, and counts bytes that are not commands.
module uart_cmd_decoder #(
  parameter int unsigned HOLD_CLKS = 2_500_000,
  parameter int unsigned HOLD_W    = 22
) (
  input  logic clk_i,
  input  logic rst_i,
  uart_cmd_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} mode_e;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h70;
  localparam logic [7:0] CMD_QUIT  = 8'h71;
  localparam logic [7:0] CMD_SPACE = 8'h20;
  localparam logic [7:0] CMD_P1_UP = 8'h77;
  localparam logic [7:0] CMD_P1_DN = 8'h73;
  localparam logic [7:0] CMD_P2_UP = 8'h6F;
  localparam logic [7:0] CMD_P2_DN = 8'h6C;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CLKS);

  // Index of each paddle direction in the hold array; partners differ in bit 0.
  localparam int P1_UP = 0;
  localparam int P1_DN = 1;
  localparam int P2_UP = 2;
  localparam int P2_DN = 3;

  logic              rx_dv_q;
  logic [7:0]        rx_byte_q;
  mode_e             mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q [4];
  logic [HOLD_W-1:0] hold_d [4];
  logic              start_q, start_d;
  logic [7:0]        bad_q, bad_d;
  logic [3:0]        pad_q, pad_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_dv_q   <= 1'b0;
      rx_byte_q <= '0;
      mode_q    <= IDLE;
      start_q   <= 1'b0;
      bad_q     <= '0;
      pad_q     <= '0;
      // NOTE: only four counters, so they are plain flops and are reset like any others.
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the values from before this edge.
      rx_dv_q   <= bus.rx_dv_i;
      rx_byte_q <= bus.rx_byte_i;
      mode_q    <= mode_d;
      start_q   <= start_d;
      bad_q     <= bad_d;
      pad_q     <= pad_d;
      for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    mode_d  = mode_q;
    start_d = 1'b0;
    bad_d   = bad_q;
    for (int i = 0; i < 4; i++) hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - HOLD_W'(1) : '0;

    if (rx_dv_q) begin
      unique case (rx_byte_q)
        CMD_START: begin
          if (mode_q != RUN) begin
            mode_d  = RUN;
            start_d = 1'b1;
          end
        end
        CMD_PAUSE: begin
          if (mode_q == RUN) begin
            mode_d = PAUSE;
            for (int i = 0; i < 4; i++) hold_d[i] = '0;
          end else if (mode_q == PAUSE) begin
            mode_d = RUN;
          end
        end
        CMD_QUIT: begin
          if (mode_q != IDLE) begin
            mode_d = IDLE;
            for (int i = 0; i < 4; i++) hold_d[i] = '0;
          end
        end
        CMD_SPACE: begin
          if (mode_q == RUN) begin
            for (int i = 0; i < 4; i++) hold_d[i] = '0;
          end
        end
        CMD_P1_UP, CMD_P1_DN, CMD_P2_UP, CMD_P2_DN: begin
          if (mode_q == RUN) begin
            // Loading one direction kills its partner, so the latest key always wins.
            unique case (rx_byte_q)
              CMD_P1_UP: begin hold_d[P1_UP] = HOLD_LOAD; hold_d[P1_DN] = '0; end
              CMD_P1_DN: begin hold_d[P1_DN] = HOLD_LOAD; hold_d[P1_UP] = '0; end
              CMD_P2_UP: begin hold_d[P2_UP] = HOLD_LOAD; hold_d[P2_DN] = '0; end
              default:   begin hold_d[P2_DN] = HOLD_LOAD; hold_d[P2_UP] = '0; end
            endcase
          end
        end
        default: begin
          if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
        end
      endcase
    end

    for (int i = 0; i < 4; i++) pad_d[i] = (hold_d[i] != '0) && (mode_d == RUN);
  end

  assign bus.game_start_o  = start_q;
  assign bus.p1_up_o       = pad_q[P1_UP];
  assign bus.p1_down_o     = pad_q[P1_DN];
  assign bus.p2_up_o       = pad_q[P2_UP];
  assign bus.p2_down_o     = pad_q[P2_DN];
  assign bus.mode_o        = mode_q;
  assign bus.bad_cmd_cnt_o = bad_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder with HOLD_CLKS=10: a table of byte/expected-output
// vectors run through a scoreboard queue, plus paddle hold traces and an async reset pulse.
module tb_uart_cmd_decoder;

  localparam int HOLD = 10;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] mode;
    logic       start;
    logic [7:0] bad;
    logic [3:0] pad;   // {p1_up, p1_down, p2_up, p2_down}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t vecs[$];
  vec_t sb[$];

  logic [39:0] tr_p1u, tr_p1d, tr_p2u, tr_p2d;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .HOLD_CLKS(HOLD),
    .HOLD_W   (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] b, input logic [1:0] mode, input logic start,
                              input logic [7:0] bad, input logic [3:0] pad);
    vec_t v;
    v.b = b; v.mode = mode; v.start = start; v.bad = bad; v.pad = pad;
    return v;
  endfunction

  function automatic logic [3:0] pads();
    return {bus.p1_up_o, bus.p1_down_o, bus.p2_up_o, bus.p2_down_o};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One-cycle strobe; the byte is captured on the posedge between the two negedges.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dv_i   = 1'b1;
    bus.rx_byte_i = b;
    @(negedge clk);
    bus.rx_dv_i   = 1'b0;
  endtask

  // The decoded result shows up one edge after capture, i.e. at the next negedge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    sb.push_back(v);
    send(v.b);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, " mode"},  bus.mode_o,        e.mode);
    check({tag, " start"}, bus.game_start_o,  e.start);
    check({tag, " bad"},   bus.bad_cmd_cnt_o, e.bad);
    check({tag, " pads"},  pads(),            e.pad);
    if (e.start) begin
      @(negedge clk);
      check({tag, " start width"}, bus.game_start_o, 1'b0);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tr_p1u[i] = bus.p1_up_o;
      tr_p1d[i] = bus.p1_down_o;
      tr_p2u[i] = bus.p2_up_o;
      tr_p2d[i] = bus.p2_down_o;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_dv_i   = 1'b0;
    bus.rx_byte_i = 8'h00;

    // Byte, mode, start, bad count, pads -- walking through every mode transition.
    vecs.push_back(mk(8'h77, 2'd0, 1'b0, 8'd0, 4'h0)); // w in IDLE ignored
    vecs.push_back(mk(8'h70, 2'd0, 1'b0, 8'd0, 4'h0)); // p in IDLE ignored
    vecs.push_back(mk(8'h41, 2'd0, 1'b0, 8'd1, 4'h0)); // 'A' bad
    vecs.push_back(mk(8'hFF, 2'd0, 1'b0, 8'd2, 4'h0)); // 0xFF bad
    vecs.push_back(mk(8'h71, 2'd0, 1'b0, 8'd2, 4'h0)); // q in IDLE ignored
    vecs.push_back(mk(8'h20, 2'd0, 1'b0, 8'd2, 4'h0)); // space in IDLE ignored
    vecs.push_back(mk(8'h53, 2'd1, 1'b1, 8'd2, 4'h0)); // S -> RUN with pulse
    vecs.push_back(mk(8'h53, 2'd1, 1'b0, 8'd2, 4'h0)); // S in RUN ignored
    vecs.push_back(mk(8'h00, 2'd1, 1'b0, 8'd3, 4'h0)); // NUL bad in RUN
    vecs.push_back(mk(8'h77, 2'd1, 1'b0, 8'd3, 4'h8)); // w -> p1_up
    vecs.push_back(mk(8'h70, 2'd2, 1'b0, 8'd3, 4'h0)); // p -> PAUSE, holds cleared
    vecs.push_back(mk(8'h77, 2'd2, 1'b0, 8'd3, 4'h0)); // w in PAUSE ignored
    vecs.push_back(mk(8'h20, 2'd2, 1'b0, 8'd3, 4'h0)); // space in PAUSE ignored
    vecs.push_back(mk(8'h70, 2'd1, 1'b0, 8'd3, 4'h0)); // p -> RUN, no pulse
    vecs.push_back(mk(8'h6F, 2'd1, 1'b0, 8'd3, 4'h2)); // o -> p2_up
    vecs.push_back(mk(8'h6C, 2'd1, 1'b0, 8'd3, 4'h1)); // l -> p2_down replaces p2_up
    vecs.push_back(mk(8'h73, 2'd1, 1'b0, 8'd3, 4'h5)); // s -> p1_down, p2_down still held
    vecs.push_back(mk(8'h77, 2'd1, 1'b0, 8'd3, 4'h9)); // w -> p1_up replaces p1_down
    vecs.push_back(mk(8'h20, 2'd1, 1'b0, 8'd3, 4'h0)); // space releases all
    vecs.push_back(mk(8'h70, 2'd2, 1'b0, 8'd3, 4'h0)); // p -> PAUSE
    vecs.push_back(mk(8'h53, 2'd1, 1'b1, 8'd3, 4'h0)); // S from PAUSE -> RUN with pulse
    vecs.push_back(mk(8'h50, 2'd1, 1'b0, 8'd4, 4'h0)); // 'P' is case-sensitive bad
    vecs.push_back(mk(8'h71, 2'd0, 1'b0, 8'd4, 4'h0)); // q -> IDLE
    vecs.push_back(mk(8'h73, 2'd0, 1'b0, 8'd4, 4'h0)); // s in IDLE ignored
    vecs.push_back(mk(8'h53, 2'd1, 1'b1, 8'd4, 4'h0)); // S -> RUN again

    repeat (2) @(negedge clk);
    check("reset mode",  bus.mode_o,        2'd0);
    check("reset start", bus.game_start_o,  1'b0);
    check("reset bad",   bus.bad_cmd_cnt_o, 8'd0);
    check("reset pads",  pads(),            4'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Single 'w': exactly HOLD cycles high, starting on the first sample.
    send(8'h77);
    capture();
    check("single hold p1_up", tr_p1u, 40'h3FF);

    // Second 'w' loads five cycles after the first: 15 contiguous cycles.
    send(8'h77);
    fork
      capture();
      begin
        repeat (3) @(negedge clk);
        send(8'h77);
      end
    join
    check("reload hold p1_up", tr_p1u, 40'h7FFF);

    // 'w', then 'o', then 's': p1 hands over on one edge, p2 unaffected by 's'.
    send(8'h77);
    fork
      capture();
      begin
        send(8'h6F);
        send(8'h73);
      end
    join
    check("cross p1_up",     tr_p1u,          40'hF);
    check("cross p1_down",   tr_p1d,          40'h3FF0);
    check("cross p2_up",     tr_p2u,          40'hFFC);
    check("cross p2_down",   tr_p2d,          40'h0);
    check("cross p1 exclusive", tr_p1u & tr_p1d, 40'h0);

    // Saturation: 300 more non-command bytes from IDLE.
    apply(mk(8'h71, 2'd0, 1'b0, 8'd4, 4'h0), "quit");
    for (int i = 0; i < 300; i++) send(8'h80 | 8'(i % 128));
    @(negedge clk);
    check("sat bad",  bus.bad_cmd_cnt_o, 8'd255);
    check("sat mode", bus.mode_o,        2'd0);
    check("sat pads", pads(),            4'h0);
    apply(mk(8'h3F, 2'd0, 1'b0, 8'd255, 4'h0), "sat hold");

    // Short asynchronous reset mid-hold, no clock edge while it is high.
    apply(mk(8'h53, 2'd1, 1'b1, 8'd255, 4'h0), "pre-rst start");
    apply(mk(8'h77, 2'd1, 1'b0, 8'd255, 4'h8), "pre-rst w");
    #2 rst = 1'b1;
    #1;
    check("async rst p1_up", bus.p1_up_o,       1'b0);
    check("async rst mode",  bus.mode_o,        2'd0);
    check("async rst bad",   bus.bad_cmd_cnt_o, 8'd0);
    #1 rst = 1'b0;
    apply(mk(8'h53, 2'd1, 1'b1, 8'd0, 4'h0), "post-rst start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
